// File: rtl/bcd_seg_mux.sv
// Two-digit multiplexed 7-segment driver with per-frame digit snapshot,
// dead-gap ghost suppression, optional leading-zero blanking and output polarity control.
module bcd_seg_mux #(
  parameter int REFRESH_DIV    = 50000,
  parameter int DEAD_CYCLES    = 16,
  parameter int BLANK_LEADING  = 1,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] digit1,
  input  logic [3:0] digit0,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       frame_tick
);

  localparam int CNT_MAX = (REFRESH_DIV > DEAD_CYCLES) ? REFRESH_DIV : DEAD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam bit HAS_DEAD = (DEAD_CYCLES > 0);
  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);

  typedef enum logic [1:0] {SHOW0, DEAD0, SHOW1, DEAD1} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       snap1, snap0;
  logic             slot_done;
  logic             load_snap;
  logic [6:0]       seg_act;
  logic [1:0]       an_act;

  function automatic logic [6:0] dec7(input logic [3:0] d);
    case (d)
      4'd0:    dec7 = 7'h3F;
      4'd1:    dec7 = 7'h06;
      4'd2:    dec7 = 7'h5B;
      4'd3:    dec7 = 7'h4F;
      4'd4:    dec7 = 7'h66;
      4'd5:    dec7 = 7'h6D;
      4'd6:    dec7 = 7'h7D;
      4'd7:    dec7 = 7'h07;
      4'd8:    dec7 = 7'h7F;
      4'd9:    dec7 = 7'h6F;
      default: dec7 = 7'h40;
    endcase
  endfunction

  always_comb begin
    state_nxt = state;
    case (state)
      SHOW0: if (cnt == SHOW_LAST) state_nxt = HAS_DEAD ? DEAD0 : SHOW1;
      DEAD0: if (cnt == DEAD_LAST) state_nxt = SHOW1;
      SHOW1: if (cnt == SHOW_LAST) state_nxt = HAS_DEAD ? DEAD1 : SHOW0;
      DEAD1: if (cnt == DEAD_LAST) state_nxt = SHOW0;
      default: state_nxt = SHOW0;
    endcase
    slot_done = (state_nxt != state);
    load_snap = slot_done && (state_nxt == SHOW0);
  end

  // Outputs depend only on registered state and en, never on the live digit inputs
  always_comb begin
    seg_act = 7'h00;
    an_act  = 2'b00;
    if (en) begin
      case (state)
        SHOW0: begin
          an_act  = 2'b01;
          seg_act = dec7(snap0);
        end
        SHOW1: begin
          if (!((BLANK_LEADING != 0) && (snap1 == 4'd0))) begin
            an_act  = 2'b10;
            seg_act = dec7(snap1);
          end
        end
        default: begin
          an_act  = 2'b00;
          seg_act = 7'h00;
        end
      endcase
    end
    seg = (SEG_ACTIVE_LOW != 0) ? ~seg_act : seg_act;
    an  = (AN_ACTIVE_LOW != 0) ? ~an_act : an_act;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= SHOW0;
      cnt        <= '0;
      snap1      <= 4'd0;
      snap0      <= 4'd0;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= slot_done ? '0 : cnt + 1'b1;
      frame_tick <= load_snap;
      if (load_snap) begin
        snap1 <= digit1;
        snap0 <= digit0;
      end
    end
  end

endmodule

// File: tb/tb_bcd_seg_mux.sv
// Bench for bcd_seg_mux: three parameterisations share stimulus and are checked every
// cycle against a frame-position model, plus hand-computed literal expectations.
module tb_bcd_seg_mux;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic [3:0] digit1 = 4'd0;
  logic [3:0] digit0 = 4'd0;

  logic [6:0] seg_a, seg_b, seg_c;
  logic [1:0] an_a, an_b, an_c;
  logic       ft_a, ft_b, ft_c;

  int checks = 0;
  int failures = 0;
  bit running = 1'b1;
  int tcur = 0;

  always #5 clk = ~clk;

  bcd_seg_mux #(.REFRESH_DIV(4), .DEAD_CYCLES(2), .BLANK_LEADING(1)) u_a (
    .clk(clk), .rst(rst), .en(en), .digit1(digit1), .digit0(digit0),
    .seg(seg_a), .an(an_a), .frame_tick(ft_a));
  bcd_seg_mux #(.REFRESH_DIV(4), .DEAD_CYCLES(2), .BLANK_LEADING(0)) u_b (
    .clk(clk), .rst(rst), .en(en), .digit1(digit1), .digit0(digit0),
    .seg(seg_b), .an(an_b), .frame_tick(ft_b));
  bcd_seg_mux #(.REFRESH_DIV(4), .DEAD_CYCLES(0), .BLANK_LEADING(1)) u_c (
    .clk(clk), .rst(rst), .en(en), .digit1(digit1), .digit0(digit0),
    .seg(seg_c), .an(an_c), .frame_tick(ft_c));

  // Model state: cycles since reset release and the digit pair captured at each frame start
  int         mt [3];
  logic [3:0] ms1 [3];
  logic [3:0] ms0 [3];
  localparam int FR [3] = '{12, 12, 8};

  always @(posedge clk or negedge rst) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst) begin
        mt[i]  <= 0;
        ms1[i] <= 4'd0;
        ms0[i] <= 4'd0;
      end else begin
        mt[i] <= mt[i] + 1;
        if ((mt[i] + 1) % FR[i] == 0) begin
          ms1[i] <= digit1;
          ms0[i] <= digit0;
        end
      end
    end
  end

  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] tab [10];
    tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    if (d > 4'd9) return 7'h40;
    return tab[d];
  endfunction

  // Returns {frame_tick, an, seg} as seen on the pins (both active-low).
  function automatic logic [9:0] model(input int r, input int d, input bit bl, input int t,
                                       input logic [3:0] s1, input logic [3:0] s0,
                                       input logic en_v);
    int f, p;
    logic [1:0] a;
    logic [6:0] s;
    f = 2 * (r + d);
    p = t % f;
    a = 2'b00;
    s = 7'h00;
    if (p < r) begin
      a = 2'b01;
      s = glyph(s0);
    end else if (p >= r + d && p < 2 * r + d && !(bl && s1 == 4'd0)) begin
      a = 2'b10;
      s = glyph(s1);
    end
    if (!en_v) begin
      a = 2'b00;
      s = 7'h00;
    end
    return {(t >= f && p == 0), ~a, ~s};
  endfunction

  task automatic chk(input string name, input logic [9:0] got, input logic [9:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0d got=%b expected=%b", name, tcur, got, exp);
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (running) begin
      chk("a_model", {ft_a, an_a, seg_a}, model(4, 2, 1'b1, mt[0], ms1[0], ms0[0], en));
      chk("b_model", {ft_b, an_b, seg_b}, model(4, 2, 1'b0, mt[1], ms1[1], ms0[1], en));
      chk("c_model", {ft_c, an_c, seg_c}, model(4, 0, 1'b1, mt[2], ms1[2], ms0[2], en));
      chk("an_excl", {7'b0, an_a == 2'b00, an_b == 2'b00, an_c == 2'b00}, 10'b0);
    end
  end

  task automatic go_to(input int target);
    while (tcur < target) begin
      @(negedge clk);
      tcur++;
    end
  endtask

  initial begin
    #1 rst = 1'b0;
    digit1 = 4'd4;
    digit0 = 4'd2;
    repeat (3) @(negedge clk);
    #3 chk("reset_vals", {ft_a, an_a, seg_a}, {1'b0, 2'b10, 7'b1000000});
    @(negedge clk);
    rst = 1'b1;
    tcur = 0;
    #3 chk("a_t0_units0", {ft_a, an_a, seg_a}, {1'b0, 2'b10, 7'b1000000});
    go_to(4);  #3 chk("a_dead0", {ft_a, an_a, seg_a}, {1'b0, 2'b11, 7'b1111111});
    go_to(6);  #3 chk("a_tens_blank", {ft_a, an_a, seg_a}, {1'b0, 2'b11, 7'b1111111});
    chk("b_tens_zero", {ft_b, an_b, seg_b}, {1'b0, 2'b01, 7'b1000000});
    go_to(10); #3 chk("a_dead1", {ft_a, an_a, seg_a}, {1'b0, 2'b11, 7'b1111111});
    go_to(12); #3 chk("a_tick_units2", {ft_a, an_a, seg_a}, {1'b1, 2'b10, 7'b0100100});
    chk("c_tens4", {ft_c, an_c, seg_c}, {1'b0, 2'b01, 7'b0011001});
    go_to(18); #3 chk("a_tens4", {ft_a, an_a, seg_a}, {1'b0, 2'b01, 7'b0011001});
    go_to(19); digit0 = 4'd7;
    go_to(24); #3 chk("a_units7", {ft_a, an_a, seg_a}, {1'b1, 2'b10, 7'b1111000});
    go_to(25); digit1 = 4'd12;
    go_to(42); #3 chk("a_tens_dash", {ft_a, an_a, seg_a}, {1'b0, 2'b01, 7'b0111111});
    go_to(49); en = 1'b0;
    #3 chk("a_en_off", {ft_a, an_a, seg_a}, {1'b0, 2'b11, 7'b1111111});
    go_to(54); en = 1'b1;
    go_to(60); #3 chk("a_tick_after_en", {ft_a, an_a, seg_a}, {1'b1, 2'b10, 7'b1111000});
    go_to(64); rst = 1'b0;
    #3 chk("a_rst_async", {ft_a, an_a, seg_a}, {1'b0, 2'b10, 7'b1000000});
    @(negedge clk);
    rst = 1'b1;
    tcur = 0;
    go_to(11); #3 chk("a_no_tick_yet", {ft_a, an_a, seg_a}, {1'b0, 2'b11, 7'b1111111});
    go_to(12); #3 chk("a_tick_post_rst", {ft_a, an_a, seg_a}, {1'b1, 2'b10, 7'b1111000});
    go_to(30);
    running = 1'b0;
    @(negedge clk);
    #5;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
